// File: rtl/capture_control.sv
// Capture sequencer: arms the trigger, keeps pre-trigger history in a circular sample RAM,
// records the post-trigger window and streams it out oldest-first. Optional: FORCE_TRIG_EN.
module capture_control #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    valid,
    input  logic [SAMPLE_WIDTH-1:0] dataIn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   preCount,
    input  logic [ADDR_WIDTH:0]     postCount,
    input  logic                    run,
`ifdef FORCE_TRIG_EN
    input  logic                    force_trig,
`endif
    output logic                    arm,
    input  logic                    rd_req,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    rd_last,
    output logic                    busy,
    output logic                    done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH+1:0] L_DEPTH  = (ADDR_WIDTH+2)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   L_DEPTH1 = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   L_ONE    = (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE,
        S_READ
    } state_t;

    state_t                  r_state;
    logic [SAMPLE_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [ADDR_WIDTH-1:0]   r_pre;
    logic [ADDR_WIDTH-1:0]   r_pre_cnt;
    logic [ADDR_WIDTH:0]     r_post;
    logic [ADDR_WIDTH:0]     r_post_cnt;
    logic [ADDR_WIDTH:0]     r_rd_rem;
    logic [SAMPLE_WIDTH-1:0] r_rd_data;
    logic                    r_arm;
    logic                    r_rd_valid;
    logic                    r_rd_last;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_trig;
    logic                    w_post_full;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic [ADDR_WIDTH+1:0]   w_post_ext;
    logic [ADDR_WIDTH+1:0]   w_sum;
    logic [ADDR_WIDTH:0]     w_post_lim;
    logic [ADDR_WIDTH:0]     w_window;

`ifdef FORCE_TRIG_EN
    assign w_trig = run | force_trig;
`else
    assign w_trig = run;
`endif

    assign w_post_full = (r_post_cnt == r_post);
    assign w_wr_en     = valid && ((r_state == S_PRE) || (r_state == S_WAIT) ||
                                   ((r_state == S_POST) && !w_post_full));
    assign w_rd_en     = rd_req && !abort && ((r_state == S_DONE) || (r_state == S_READ));

    // A zero post count still captures the trigger sample; the window never exceeds the buffer.
    assign w_post_ext  = (postCount == '0) ? (ADDR_WIDTH+2)'(1) : {1'b0, postCount};
    assign w_sum       = {2'b00, preCount} + w_post_ext;
    assign w_post_lim  = (w_sum > L_DEPTH) ? (L_DEPTH1 - {1'b0, preCount})
                                           : w_post_ext[ADDR_WIDTH:0];
    assign w_window    = {1'b0, r_pre} + r_post;

    // NOTE: the sample RAM has no reset so it maps onto block RAM; every word read back
    // was written earlier in the same capture, so its power-up contents never matter.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= dataIn;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every branch sees the
    // pre-edge values, regardless of the order the statements appear in.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_addr  <= '0;
            r_pre      <= '0;
            r_pre_cnt  <= '0;
            r_post     <= '0;
            r_post_cnt <= '0;
            r_rd_rem   <= '0;
            r_rd_data  <= '0;
            r_arm      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_arm      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;

            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_rd_en) begin
                r_rd_data  <= r_mem[r_rd_addr];
                r_rd_valid <= 1'b1;
                r_rd_last  <= (r_rd_rem == L_ONE);
                r_rd_addr  <= r_rd_addr + 1'b1;
                r_rd_rem   <= r_rd_rem - 1'b1;
            end

            if (abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_pre   <= preCount;
                            r_post  <= w_post_lim;
                            r_arm   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        r_wr_ptr  <= '0;
                        r_pre_cnt <= '0;
                        r_state   <= S_PRE;
                    end
                    S_PRE: begin
                        if (r_pre_cnt == r_pre) begin
                            r_state <= S_WAIT;
                        end else if (valid) begin
                            r_pre_cnt <= r_pre_cnt + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (w_trig) begin
                            r_post_cnt <= {{ADDR_WIDTH{1'b0}}, valid};
                            r_state    <= S_POST;
                        end
                    end
                    S_POST: begin
                        if (w_post_full) begin
                            // The window ends just before wr_ptr, so its start is wr_ptr - (pre+post).
                            r_rd_addr <= r_wr_ptr - w_window[ADDR_WIDTH-1:0];
                            r_rd_rem  <= w_window;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (valid) begin
                            r_post_cnt <= r_post_cnt + 1'b1;
                        end
                    end
                    S_DONE, S_READ: begin
                        if (w_rd_en) begin
                            if (r_rd_rem == L_ONE) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_READ;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign arm      = r_arm;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
